fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined core. It replaces direct combinational indexing of a flat code bus with a request/response instruction-memory interface and a DEPTH-entry prefetch queue. It issues sequential fetches, absorbs variable memory latency and decode-stage stalls, and discards in-flight work on a branch or jump redirect. It sits between instruction memory and the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, entry layout and sizing helper for the fetch front end.
// No ports; imported by fetch_fifo and fetch_queue.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    // Queue entry layout for the default 32-bit core.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_next;
    } fetch_entry_t;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two FIFO with synchronous clear and same-cycle push/pop.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   clr            synchronous flush (empties the FIFO)
//   push, din      write din at the tail
//   pop            drop the head
//   dout           head entry (meaningful only while count != 0)
//   count          occupancy, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd;
    logic [AW-1:0]    wr;

    assign dout = mem[rd];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two; push and pop
    // together leave count unchanged, which keeps a full FIFO streaming.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            rd    <= rd + AW'(pop);
            wr    <= wr + AW'(push);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with request/response memory port and prefetch queue.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (zero-latency response bypass when queue is empty).
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   req_valid/req_ready/req_addr    fetch request toward instruction memory
//   resp_valid/resp_data            in-order memory response, always accepted
//   out_valid/out_ready             head entry handshake toward IF/ID
//   out_instr/out_pc_next           head instruction and its fetch address + 4
//   redirect_valid/redirect_pc      taken branch/jump; flushes queue and in-flight work
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CW = cnt_w(DEPTH);

    logic [XLEN-1:0]   pc;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     q_cnt;
    logic [CW:0]       occ;
    logic [XLEN-1:0]   a_head;
    logic [2*XLEN-1:0] q_head;
    logic [2*XLEN-1:0] held;
    logic              fire;
    logic              drop;
    logic              byp;
    logic              q_push;
    logic              q_pop;
    logic              q_any;

    // Slots already promised: queued entries plus responses that will be kept.
    assign occ = {1'b0, q_cnt} + {1'b0, inflight} - {1'b0, discard};

    assign req_valid = !reset && !redirect_valid && (occ < (CW+1)'(DEPTH)) && (inflight < CW'(DEPTH));
    assign req_addr  = pc;
    assign fire      = req_valid && req_ready;
    assign drop      = discard != '0;
    assign q_any     = q_cnt != '0;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = !reset && !redirect_valid && !q_any && !drop && resp_valid;
`else
    assign byp = 1'b0;
`endif

    assign q_push    = resp_valid && !drop && !redirect_valid && !(byp && out_ready);
    assign q_pop     = q_any && out_ready && !redirect_valid;
    assign out_valid = !reset && !redirect_valid && (q_any || byp);

    // When nothing is presented the outputs fall back to the last shown entry.
    assign {out_instr, out_pc_next} = q_any ? q_head : byp ? {resp_data, a_head} : held;

    always_ff @(posedge clk) begin
        if (reset)
            held <= '0;
        else if (q_any || byp)
            held <= {out_instr, out_pc_next};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            discard <= '0;
        end else if (redirect_valid) begin
            pc      <= redirect_pc & ~XLEN'(INSTR_BYTES - 1);
            discard <= inflight - CW'(resp_valid);
        end else begin
            if (fire)
                pc <= pc + XLEN'(INSTR_BYTES);
            if (resp_valid && drop)
                discard <= discard - CW'(1);
        end
    end

    // Address FIFO runs in step with the memory: one push per accepted request,
    // one pop per response (kept or dropped), so its occupancy is the in-flight
    // count and it is never flushed by a redirect.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_addr (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .push  (fire),
        .pop   (resp_valid),
        .din   (pc + XLEN'(INSTR_BYTES)),
        .dout  (a_head),
        .count (inflight)
    );

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_data (
        .clk   (clk),
        .reset (reset),
        .clr   (redirect_valid),
        .push  (q_push),
        .pop   (q_pop),
        .din   ({resp_data, a_head}),
        .dout  (q_head),
        .count (q_cnt)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue with a simple in-order memory model.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_ready = 1'b1;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        out_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc_next;

    int pass_cnt = 0;
    int total = 0;
    bit mem_en = 1'b1;

    logic [31:0]  pend[$];
    logic [31:0]  issued[$];
    fetch_entry_t got[$];

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc_next(out_pc_next),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    // Samples this cycle's transfers, advances one edge, then drives the memory response.
    task automatic cycle();
        #1;
        if (!reset) begin
            if (req_valid && req_ready) begin
                pend.push_back(req_addr);
                issued.push_back(req_addr);
            end
            if (resp_valid) void'(pend.pop_front());
            if (out_valid && out_ready) got.push_back('{instr: out_instr, pc_next: out_pc_next});
        end
        @(posedge clk);
        #1;
        if (reset) pend.delete();
        resp_valid = !reset && mem_en && pend.size() != 0;
        resp_data  = resp_valid ? f(pend[0]) : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        req_ready = 1'b1;
        out_ready = 1'b1;
        mem_en = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        pend.delete();
        issued.delete();
        got.delete();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        total++; if (req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", req_valid); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (out_instr !== 32'h0) $display("FAIL rst_out_instr got %h want 0", out_instr); else pass_cnt++;
        total++; if (out_pc_next !== 32'h0) $display("FAIL rst_out_pc_next got %h want 0", out_pc_next); else pass_cnt++;
        total++; if (req_addr !== 32'h0) $display("FAIL rst_req_addr got %h want 0", req_addr); else pass_cnt++;
        reset = 1'b0;
        #1;
        total++; if (req_valid !== 1'b1) $display("FAIL first_req_valid got %b want 1", req_valid); else pass_cnt++;
    endtask

    task automatic test_stream();
        fetch_entry_t e;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                total++; if (out_valid !== 1'b1) $display("FAIL stream_out_valid cycle %0d got %b want 1", i, out_valid); else pass_cnt++;
            end
            cycle();
        end
        total++; if (issued.size() !== 10) $display("FAIL stream_issued got %0d want 10", issued.size()); else pass_cnt++;
        total++; if (got.size() !== 8) $display("FAIL stream_got got %0d want 8", got.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            e = '{instr: f(32'(4 * i)), pc_next: 32'(4 * i + 4)};
            total++; if (got[i] !== e) $display("FAIL stream_entry %0d got %h want %h", i, got[i], e); else pass_cnt++;
            total++; if (issued[i] !== 32'(4 * i)) $display("FAIL stream_addr %0d got %h want %h", i, issued[i], 32'(4 * i)); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        fetch_entry_t e;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        total++; if (issued.size() !== 4) $display("FAIL stall_issued got %0d want 4", issued.size()); else pass_cnt++;
        total++; if (req_valid !== 1'b0) $display("FAIL stall_req_valid got %b want 0", req_valid); else pass_cnt++;
        total++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid got %b want 1", out_valid); else pass_cnt++;
        total++; if (out_instr !== 32'h13) $display("FAIL stall_head_instr got %h want 00000013", out_instr); else pass_cnt++;
        total++; if (out_pc_next !== 32'h4) $display("FAIL stall_head_pc got %h want 4", out_pc_next); else pass_cnt++;
        total++; if (got.size() !== 0) $display("FAIL stall_no_deq got %0d want 0", got.size()); else pass_cnt++;
        out_ready = 1'b1;
        cycle();
        e = '{instr: 32'h13, pc_next: 32'h4};
        total++; if (got[0] !== e) $display("FAIL stall_release got %h want %h", got[0], e); else pass_cnt++;
        total++; if (out_instr !== f(32'h4)) $display("FAIL stall_next_head got %h want %h", out_instr, f(32'h4)); else pass_cnt++;
        total++; if (req_valid !== 1'b1 || req_addr !== 32'h10) $display("FAIL stall_reissue got %b/%h want 1/00000010", req_valid, req_addr); else pass_cnt++;
    endtask

    task automatic test_redirect();
        fetch_entry_t e;
        do_reset();
        mem_en = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        #1;
        total++; if (req_valid !== 1'b0) $display("FAIL redir_req_valid got %b want 0", req_valid); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL redir_out_valid got %b want 0", out_valid); else pass_cnt++;
        cycle();
        redirect_valid = 1'b0;
        #1;
        total++; if (req_valid !== 1'b1 || req_addr !== 32'h100) $display("FAIL redir_next_req got %b/%h want 1/00000100", req_valid, req_addr); else pass_cnt++;
        mem_en = 1'b1;
        got.delete();
        for (int i = 0; i < 12; i++) cycle();
        total++; if (got.size() < 2) $display("FAIL redir_count got %0d want >=2", got.size()); else pass_cnt++;
        e = '{instr: f(32'h100), pc_next: 32'h104};
        total++; if (got[0] !== e) $display("FAIL redir_first got %h want %h", got[0], e); else pass_cnt++;
        e = '{instr: f(32'h104), pc_next: 32'h108};
        total++; if (got[1] !== e) $display("FAIL redir_second got %h want %h", got[1], e); else pass_cnt++;
    endtask

    task automatic test_redirect_resp();
        fetch_entry_t e;
        do_reset();
        mem_en = 1'b0;
        cycle();
        cycle();
        req_ready = 1'b0;
        mem_en = 1'b1;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rr_out_valid got %b want 0", out_valid); else pass_cnt++;
        cycle();
        redirect_valid = 1'b0;
        req_ready = 1'b1;
        #1;
        total++; if (req_valid !== 1'b1 || req_addr !== 32'h200) $display("FAIL rr_next_req got %b/%h want 1/00000200", req_valid, req_addr); else pass_cnt++;
        got.delete();
        for (int i = 0; i < 10; i++) cycle();
        e = '{instr: f(32'h200), pc_next: 32'h204};
        total++; if (got[0] !== e) $display("FAIL rr_first got %h want %h", got[0], e); else pass_cnt++;
        e = '{instr: f(32'h204), pc_next: 32'h208};
        total++; if (got[1] !== e) $display("FAIL rr_second got %h want %h", got[1], e); else pass_cnt++;
    endtask

    task automatic test_wrap();
        fetch_entry_t e;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        cycle();
        redirect_valid = 1'b0;
        #1;
        total++; if (req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want fffffffc", req_addr); else pass_cnt++;
        cycle();
        total++; if (req_addr !== 32'h0) $display("FAIL wrap_next got %h want 0", req_addr); else pass_cnt++;
        got.delete();
        for (int i = 0; i < 6; i++) cycle();
        e = '{instr: f(32'hFFFF_FFFC), pc_next: 32'h0};
        total++; if (got[0] !== e) $display("FAIL wrap_entry got %h want %h", got[0], e); else pass_cnt++;
        e = '{instr: f(32'h0), pc_next: 32'h4};
        total++; if (got[1] !== e) $display("FAIL wrap_after got %h want %h", got[1], e); else pass_cnt++;
    endtask

    task automatic test_reset_full();
        fetch_entry_t e;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rf_out_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (req_valid !== 1'b0) $display("FAIL rf_req_valid got %b want 0", req_valid); else pass_cnt++;
        cycle();
        reset = 1'b0;
        pend.delete();
        issued.delete();
        got.delete();
        #1;
        total++; if (req_valid !== 1'b1 || req_addr !== 32'h0) $display("FAIL rf_restart got %b/%h want 1/00000000", req_valid, req_addr); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL rf_empty got %b want 0", out_valid); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        e = '{instr: 32'h13, pc_next: 32'h4};
        total++; if (got[0] !== e) $display("FAIL rf_first got %h want %h", got[0], e); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_resp();
        test_wrap();
        test_reset_full();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
